// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: 2-flop synchroniser, then a counter debounce
// FSM per channel producing stable levels and one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  typedef enum logic {
    STABLE,
    PENDING
  } db_st_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    db_st_t           st;
    logic [CNT_W-1:0] cnt;
    logic             db_q;
    logic             rise_q;
    logic             fall_q;
    logic             diff;

    assign diff      = s2[i] ^ db_q;
    // Final qualifying sample: level is committed on this edge.
    assign accept[i] = (st == PENDING) && diff && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= STABLE;
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        unique case (st)
          STABLE: begin
            if (diff) begin
              st  <= PENDING;
              cnt <= ONE;
            end else begin
              cnt <= '0;
            end
          end
          PENDING: begin
            if (!diff) begin
              st  <= STABLE;
              cnt <= '0;
            end else if (cnt == LAST) begin
              st     <= STABLE;
              cnt    <= '0;
              db_q   <= s2[i];
              rise_q <= s2[i];
              fall_q <= ~s2[i];
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            st  <= STABLE;
            cnt <= '0;
          end
        endcase
      end
    end

    assign sw_db[i]   = db_q;
    assign sw_rise[i] = rise_q;
    assign sw_fall[i] = fall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: reset, clean steps, glitches, boundary,
// simultaneous mixed events, counting sweep, reset mid-pending.
module tb_sw_debounce;

  logic       tb_clk;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_db;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       changed;

  int checks;
  int failures;
  int n_changed;

  sw_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk    (tb_clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] e_db,
                     input logic [3:0] e_rise, input logic [3:0] e_fall,
                     input logic e_ch);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {sw_db, sw_rise, sw_fall, changed};
    exp = {e_db, e_rise, e_fall, e_ch};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed db/rise/fall/ch=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    n_changed = 0;
    rst_n     = 1'b0;
    sw_raw    = 4'b0000;
    #3;
    chk("reset_state", 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Bring all bits high, then assert reset between edges
    sw_raw = 4'b1111;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) chk("pre_all_high_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    chk("all_high_e6", 4'hF, 4'hF, 4'h0, 1'b1);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 4'h0, 4'h0, 4'h0, 1'b0);
    sw_raw = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("post_reset_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Clean step 0000 -> 0101
    sw_raw = 4'b0101;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("clean_wait", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    step();
    chk("clean_e6", 4'h5, 4'h5, 4'h0, 1'b1);
    step();
    chk("clean_e7", 4'h5, 4'h0, 4'h0, 1'b0);

    // Back to zero
    sw_raw = 4'b0000;
    for (int e = 1; e <= 5; e++) step();
    chk("fall_e5", 4'h5, 4'h0, 4'h0, 1'b0);
    step();
    chk("fall_e6", 4'h0, 4'h0, 4'h5, 1'b1);
    step();
    chk("fall_e7", 4'h0, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 4; c++) step();

    // Glitch: bit 2 high for 3 samples only
    sw_raw = 4'b0100;
    step();
    step();
    step();
    sw_raw = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("glitch_reject", 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Boundary: bit 2 high for exactly 4 samples
    sw_raw = 4'b0100;
    for (int e = 1; e <= 4; e++) step();
    sw_raw = 4'b0000;
    step();
    chk("bound_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    chk("bound_e6_rise", 4'h4, 4'h4, 4'h0, 1'b1);
    for (int e = 7; e <= 9; e++) begin
      step();
      chk("bound_hold", 4'h4, 4'h0, 4'h0, 1'b0);
    end
    step();
    chk("bound_e10_fall", 4'h0, 4'h0, 4'h4, 1'b1);
    step();
    chk("bound_e11", 4'h0, 4'h0, 4'h0, 1'b0);

    // Mixed simultaneous events: 0011 -> 1100
    sw_raw = 4'b0011;
    for (int c = 0; c < 8; c++) step();
    chk("mixed_setup", 4'h3, 4'h0, 4'h0, 1'b0);
    sw_raw = 4'b1100;
    for (int e = 1; e <= 5; e++) step();
    chk("mixed_e5", 4'h3, 4'h0, 4'h0, 1'b0);
    step();
    chk("mixed_e6", 4'hC, 4'hC, 4'h3, 1'b1);
    step();
    chk("mixed_e7", 4'hC, 4'h0, 4'h0, 1'b0);

    // Counting sweep 0..15 starting from 1100
    for (int v = 0; v < 16; v++) begin
      sw_raw = 4'(v);
      for (int c = 0; c < 10; c++) begin
        step();
        if (changed === 1'b1) n_changed++;
        if (c == 4) begin
          checks++;
          assert (sw_db !== 4'(v) || v == 0 && sw_db === 4'(v)) else begin
            failures++;
            $error("FAIL sweep_early v=%0d observed=%b", v, sw_db);
          end
        end
        if (c == 5) begin
          checks++;
          assert (sw_db === 4'(v)) else begin
            failures++;
            $error("FAIL sweep_track observed=%b expected=%b",
                   sw_db, 4'(v));
          end
        end
      end
    end
    checks++;
    assert (n_changed === 16) else begin
      failures++;
      $error("FAIL sweep_count observed=%0d expected=16", n_changed);
    end
    chk("sweep_final", 4'hF, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of a pending count
    sw_raw = 4'b0000;
    for (int c = 0; c < 4; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("pending_reset", 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("pending_discard", 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Switch held high through reset release
    rst_n  = 1'b0;
    sw_raw = 4'b1010;
    step();
    #2;
    rst_n = 1'b1;
    #1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("held_wait", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    step();
    chk("held_e6", 4'hA, 4'hA, 4'h0, 1'b1);
    step();
    chk("held_e7", 4'hA, 4'h0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
